// File: rtl/sd_emu_pkg.sv
// Purpose: shared types and constants for the SD SPI block emulator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, block/trailer sizes, default address base and
// the saturating byte-index increment shared by the read and write paths.
package sd_emu_pkg;

  localparam int          SD_BLOCK_BYTES       = 512;
  localparam int          SD_TRAILER_BYTES     = 4;
  localparam logic [31:0] SD_ADDR_BASE_DEFAULT = 32'h0010_0000;

  typedef enum logic [3:0] {
    ST_UNINIT,
    ST_INIT_BUSY,
    ST_READY,
    ST_RD_LOAD,
    ST_RD_IDLE,
    ST_RD_BUSY,
    ST_WR_LOAD,
    ST_WR_IDLE,
    ST_WR_BUSY
  } sd_emu_state_t;

  // Index runs 0..512; 512 means "past the data payload" and sticks there.
  function automatic logic [9:0] idx_inc(input logic [9:0] idx);
    return (idx == 10'(SD_BLOCK_BYTES)) ? idx : idx + 10'd1;
  endfunction

endpackage

// File: rtl/sd_emu_ram.sv
// Purpose: single-port synchronous byte RAM backing the emulated card.
// Latency: 1 cycle read; write-first (rdata shows wdata on a write cycle).
// Backpressure: none; accepts an access every cycle.
// Ports: clk; we/addr/wdata write port; rdata registered read data.
// No reset: contents are undefined until written.
module sd_emu_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sd_spi_block_emulator.sv
// Purpose: RAM-backed stand-in for the SD SPI host (init, block read/write).
// Latency: busy rises 1 cycle after a command, held INIT/BLOCK/BYTE_CYCLES.
// Backpressure: spi_busy; byte requests must drop low between byte ops.
// Ports: clk/rst (sync, active-high); spi_rst init request; spi_block_addr,
// spi_r_block/spi_w_block sessions; spi_r_byte/spi_w_byte byte ops;
// spi_data_in write data; spi_busy, spi_data_out, spi_err (sticky), spi_crc_err.
module sd_spi_block_emulator
  import sd_emu_pkg::*;
#(
  parameter int          NUM_BLOCKS   = 4,
  parameter logic [31:0] ADDR_BASE    = SD_ADDR_BASE_DEFAULT,
  parameter int          INIT_CYCLES  = 16,
  parameter int          BLOCK_CYCLES = 8,
  parameter int          BYTE_CYCLES  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_rst,
  input  logic [31:0] spi_block_addr,
  input  logic        spi_r_block,
  input  logic        spi_r_byte,
  input  logic        spi_r_multi_block,
  input  logic        spi_w_block,
  input  logic        spi_w_byte,
  input  logic [7:0]  spi_data_in,
  output logic        spi_busy,
  output logic [7:0]  spi_data_out,
  output logic        spi_err,
  output logic        spi_crc_err
);

  localparam int          DEPTH   = NUM_BLOCKS * SD_BLOCK_BYTES;
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [9:0]  IDX_END = 10'(SD_BLOCK_BYTES);
  localparam logic [15:0] INIT_LD = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] BLK_LD  = 16'(BLOCK_CYCLES - 1);
  localparam logic [15:0] BYTE_LD = 16'(BYTE_CYCLES - 1);

  sd_emu_state_t state, state_n;
  logic [15:0]   cnt, cnt_n;
  logic [9:0]    index, index_n;
  logic [31:0]   blk, blk_n;
  logic          busy, busy_n;
  logic          err, err_n;
  logic [7:0]    data_out, data_out_n;
  // Set once the byte request has been observed low since the last accept.
  logic          r_seen, r_seen_n;
  logic          w_seen, w_seen_n;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rdata;
  logic [31:0]   addr_off;
  logic          blk_ok;
  logic          cnt_done;
  logic          r_qual;
  logic          w_qual;

  assign addr_off = spi_block_addr - ADDR_BASE;
  assign blk_ok   = (blk < 32'(NUM_BLOCKS));
  assign cnt_done = (cnt == 16'd0);
  assign r_qual   = spi_r_byte & r_seen;
  assign w_qual   = spi_w_byte & w_seen;
  // Index 512 aliases byte 0 here; that address is never used for data.
  assign ram_addr = AW'({blk, index[8:0]});

  sd_emu_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (spi_data_in),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_UNINIT;
      cnt      <= 16'd0;
      index    <= 10'd0;
      blk      <= 32'd0;
      busy     <= 1'b0;
      err      <= 1'b0;
      data_out <= 8'hFF;
      r_seen   <= 1'b0;
      w_seen   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      index    <= index_n;
      blk      <= blk_n;
      busy     <= busy_n;
      err      <= err_n;
      data_out <= data_out_n;
      r_seen   <= r_seen_n;
      w_seen   <= w_seen_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    index_n    = index;
    blk_n      = blk;
    busy_n     = busy;
    err_n      = err;
    data_out_n = data_out;
    r_seen_n   = r_seen | ~spi_r_byte;
    w_seen_n   = w_seen | ~spi_w_byte;
    ram_we     = 1'b0;

    if (spi_rst) begin
      state_n = ST_INIT_BUSY;
      cnt_n   = INIT_LD;
      busy_n  = 1'b1;
      err_n   = 1'b0;
    end else begin
      case (state)
        ST_UNINIT: begin
          if (spi_r_block || spi_w_block) err_n = 1'b1;
        end
        ST_INIT_BUSY: begin
          if (cnt_done) begin
            state_n = ST_READY;
            busy_n  = 1'b0;
          end else begin
            cnt_n = cnt - 16'd1;
          end
        end
        ST_READY: begin
          if (spi_r_multi_block || (spi_r_block && spi_w_block)) begin
            err_n = 1'b1;
          end else if (spi_r_block || spi_w_block) begin
            state_n  = spi_r_block ? ST_RD_LOAD : ST_WR_LOAD;
            blk_n    = addr_off;
            index_n  = 10'd0;
            busy_n   = 1'b1;
            cnt_n    = BLK_LD;
            r_seen_n = ~spi_r_byte;
            w_seen_n = ~spi_w_byte;
            // Out-of-range sessions still run; reads give FF, writes drop.
            if (!(addr_off < 32'(NUM_BLOCKS))) err_n = 1'b1;
          end
        end
        ST_RD_LOAD, ST_RD_BUSY: begin
          // RAM address settled on the first busy cycle, so rdata is ready here.
          if (cnt_done) begin
            busy_n     = 1'b0;
            data_out_n = (blk_ok && index != IDX_END) ? ram_rdata : 8'hFF;
            state_n    = spi_r_block ? ST_RD_IDLE : ST_READY;
          end else begin
            cnt_n = cnt - 16'd1;
          end
        end
        ST_RD_IDLE: begin
          if (!spi_r_block) begin
            state_n = ST_READY;
          end else if (r_qual) begin
            state_n  = ST_RD_BUSY;
            busy_n   = 1'b1;
            cnt_n    = BYTE_LD;
            index_n  = idx_inc(index);
            r_seen_n = 1'b0;
          end else if (w_qual) begin
            err_n    = 1'b1;
            w_seen_n = 1'b0;
          end
        end
        ST_WR_LOAD: begin
          if (cnt_done) begin
            busy_n  = 1'b0;
            state_n = spi_w_block ? ST_WR_IDLE : ST_READY;
          end else begin
            cnt_n = cnt - 16'd1;
          end
        end
        ST_WR_IDLE: begin
          if (!spi_w_block) begin
            state_n = ST_READY;
          end else if (w_qual) begin
            state_n  = ST_WR_BUSY;
            busy_n   = 1'b1;
            cnt_n    = BYTE_LD;
            w_seen_n = 1'b0;
          end else if (r_qual) begin
            err_n    = 1'b1;
            r_seen_n = 1'b0;
          end
        end
        ST_WR_BUSY: begin
          // Sampling data on the last busy cycle lets a lagging source settle.
          if (cnt_done) begin
            ram_we  = blk_ok && (index != IDX_END);
            index_n = idx_inc(index);
            busy_n  = 1'b0;
            state_n = spi_w_block ? ST_WR_IDLE : ST_READY;
          end else begin
            cnt_n = cnt - 16'd1;
          end
        end
        default: state_n = ST_UNINIT;
      endcase
    end
  end

  assign spi_busy     = busy;
  assign spi_data_out = data_out;
  assign spi_err      = err;
  assign spi_crc_err  = 1'b0;

endmodule

// File: tb/tb_sd_spi_block_emulator.sv
// Purpose: directed self-checking bench for sd_spi_block_emulator.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sd_spi_block_emulator;
  import sd_emu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_rst;
  logic [31:0] spi_block_addr;
  logic        spi_r_block;
  logic        spi_r_byte;
  logic        spi_r_multi_block;
  logic        spi_w_block;
  logic        spi_w_byte;
  logic [7:0]  spi_data_in;
  logic        spi_busy;
  logic [7:0]  spi_data_out;
  logic        spi_err;
  logic        spi_crc_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sd_spi_block_emulator dut (
    .clk               (clk),
    .rst               (rst),
    .spi_rst           (spi_rst),
    .spi_block_addr    (spi_block_addr),
    .spi_r_block       (spi_r_block),
    .spi_r_byte        (spi_r_byte),
    .spi_r_multi_block (spi_r_multi_block),
    .spi_w_block       (spi_w_block),
    .spi_w_byte        (spi_w_byte),
    .spi_data_in       (spi_data_in),
    .spi_busy          (spi_busy),
    .spi_data_out      (spi_data_out),
    .spi_err           (spi_err),
    .spi_crc_err       (spi_crc_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive busy-high samples, bounded.
  task automatic run_busy(output int len);
    len = 0;
    while (spi_busy === 1'b1 && len < 1000) begin
      len++;
      tick();
    end
  endtask

  task automatic do_init(output logic first_busy, output int len);
    spi_rst = 1'b1;
    tick();
    first_busy = spi_busy;
    spi_rst = 1'b0;
    run_busy(len);
  endtask

  task automatic open_block(input bit rd, input logic [31:0] addr, output int len);
    spi_block_addr = addr;
    if (rd) spi_r_block = 1'b1;
    else    spi_w_block = 1'b1;
    tick();
    run_busy(len);
  endtask

  task automatic close_block();
    spi_r_block = 1'b0;
    spi_w_block = 1'b0;
    tick();
  endtask

  task automatic byte_op(input bit rd, input logic [7:0] d, output int len);
    if (rd) begin
      spi_r_byte = 1'b1;
    end else begin
      spi_data_in = d;
      spi_w_byte  = 1'b1;
    end
    tick();
    run_busy(len);
    spi_r_byte = 1'b0;
    spi_w_byte = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (spi_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", spi_busy);
    end
    tests_run++;
    if (spi_data_out !== 8'hFF) begin
      tests_failed++; $display("FAIL reset_data_out: got %h expected ff", spi_data_out);
    end
    tests_run++;
    if (spi_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_err: got %b expected 0", spi_err);
    end
    tests_run++;
    if (spi_crc_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_crc_err: got %b expected 0", spi_crc_err);
    end
  endtask

  task automatic test_uninit();
    int busy_seen = 0;
    spi_block_addr = 32'h0010_0001;
    spi_r_block = 1'b1;
    repeat (4) begin
      tick();
      if (spi_busy !== 1'b0) busy_seen++;
    end
    tests_run++;
    if (busy_seen != 0) begin
      tests_failed++; $display("FAIL uninit_busy: got %0d busy cycles expected 0", busy_seen);
    end
    tests_run++;
    if (spi_err !== 1'b1) begin
      tests_failed++; $display("FAIL uninit_err: got %b expected 1", spi_err);
    end
    close_block();
  endtask

  task automatic test_init();
    logic fb;
    int   len;
    do_init(fb, len);
    tests_run++;
    if (fb !== 1'b1) begin
      tests_failed++; $display("FAIL init_busy_rise: got %b expected 1", fb);
    end
    tests_run++;
    if (len != 16) begin
      tests_failed++; $display("FAIL init_busy_len: got %0d expected 16", len);
    end
    tests_run++;
    if (spi_err !== 1'b0) begin
      tests_failed++; $display("FAIL init_err_clear: got %b expected 0", spi_err);
    end
  endtask

  task automatic test_write_read();
    int len;
    int bad_len = 0;
    logic [7:0] exp;
    open_block(1'b0, 32'h0010_0001, len);
    tests_run++;
    if (len != 8) begin
      tests_failed++; $display("FAIL wr_load_len: got %0d expected 8", len);
    end
    for (int i = 0; i < SD_BLOCK_BYTES + SD_TRAILER_BYTES; i++) begin
      byte_op(1'b0, (i < SD_BLOCK_BYTES) ? 8'(i) : 8'hA5, len);
      if (len != 3) bad_len++;
    end
    tests_run++;
    if (bad_len != 0) begin
      tests_failed++; $display("FAIL wr_byte_len: got %0d bad windows expected 0", bad_len);
    end
    close_block();
    open_block(1'b1, 32'h0010_0001, len);
    tests_run++;
    if (len != 8) begin
      tests_failed++; $display("FAIL rd_load_len: got %0d expected 8", len);
    end
    tests_run++;
    if (spi_data_out !== 8'h00) begin
      tests_failed++; $display("FAIL rd_byte0: got %h expected 00", spi_data_out);
    end
    bad_len = 0;
    for (int k = 1; k <= SD_BLOCK_BYTES + 1; k++) begin
      byte_op(1'b1, 8'h00, len);
      if (len != 3) bad_len++;
      exp = (k >= SD_BLOCK_BYTES) ? 8'hFF : 8'(k);
      tests_run++;
      if (spi_data_out !== exp) begin
        tests_failed++;
        $display("FAIL rd_byte_%0d: got %h expected %h", k, spi_data_out, exp);
      end
    end
    tests_run++;
    if (bad_len != 0) begin
      tests_failed++; $display("FAIL rd_byte_len: got %0d bad windows expected 0", bad_len);
    end
    tests_run++;
    if (spi_err !== 1'b0) begin
      tests_failed++; $display("FAIL wr_rd_err: got %b expected 0", spi_err);
    end
    close_block();
  endtask

  task automatic test_out_of_range();
    int   len;
    logic fb;
    int   ff_bad = 0;
    open_block(1'b0, 32'h0010_0000, len);
    for (int i = 0; i < 4; i++) byte_op(1'b0, 8'hC0 + 8'(i), len);
    close_block();
    open_block(1'b1, 32'h0010_0004, len);
    tests_run++;
    if (spi_err !== 1'b1) begin
      tests_failed++; $display("FAIL oor_err: got %b expected 1", spi_err);
    end
    if (spi_data_out !== 8'hFF) ff_bad++;
    for (int i = 0; i < 3; i++) begin
      byte_op(1'b1, 8'h00, len);
      if (spi_data_out !== 8'hFF) ff_bad++;
    end
    tests_run++;
    if (ff_bad != 0) begin
      tests_failed++; $display("FAIL oor_read_ff: got %0d non-ff bytes expected 0", ff_bad);
    end
    close_block();
    open_block(1'b0, 32'h0010_0004, len);
    for (int i = 0; i < 4; i++) byte_op(1'b0, 8'h5A, len);
    close_block();
    do_init(fb, len);
    open_block(1'b1, 32'h0010_0000, len);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (spi_data_out !== 8'hC0 + 8'(i)) begin
        tests_failed++;
        $display("FAIL oor_blk0_byte%0d: got %h expected %h", i, spi_data_out, 8'hC0 + 8'(i));
      end
      byte_op(1'b1, 8'h00, len);
    end
    close_block();
  endtask

  task automatic test_hold_high();
    int len;
    int busy_cnt = 0;
    open_block(1'b1, 32'h0010_0001, len);
    spi_r_byte = 1'b1;
    repeat (15) begin
      tick();
      if (spi_busy === 1'b1) busy_cnt++;
    end
    tests_run++;
    if (busy_cnt != 3) begin
      tests_failed++; $display("FAIL hold_busy_cycles: got %0d expected 3", busy_cnt);
    end
    tests_run++;
    if (spi_data_out !== 8'h01) begin
      tests_failed++; $display("FAIL hold_one_advance: got %h expected 01", spi_data_out);
    end
    spi_r_byte = 1'b0;
    tick();
    byte_op(1'b1, 8'h00, len);
    tests_run++;
    if (spi_data_out !== 8'h02) begin
      tests_failed++; $display("FAIL hold_second_advance: got %h expected 02", spi_data_out);
    end
    close_block();
  endtask

  task automatic test_rst_mid_read();
    int len;
    open_block(1'b1, 32'h0010_0001, len);
    for (int i = 0; i < 100; i++) byte_op(1'b1, 8'h00, len);
    tests_run++;
    if (spi_data_out !== 8'h64) begin
      tests_failed++; $display("FAIL mid_read_byte100: got %h expected 64", spi_data_out);
    end
    spi_w_byte = 1'b1;
    tick();
    spi_w_byte = 1'b0;
    tests_run++;
    if (spi_err !== 1'b1 || spi_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrong_dir: got err=%b busy=%b expected err=1 busy=0", spi_err, spi_busy);
    end
    spi_rst = 1'b1;
    tick();
    spi_rst = 1'b0;
    spi_r_block = 1'b0;
    tests_run++;
    if (spi_busy !== 1'b1 || spi_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_rst_next: got busy=%b err=%b expected busy=1 err=0", spi_busy, spi_err);
    end
    run_busy(len);
    tests_run++;
    if (len != 16) begin
      tests_failed++; $display("FAIL mid_rst_len: got %0d expected 16", len);
    end
  endtask

  task automatic test_both_high();
    int   len;
    logic fb;
    int   busy_seen = 0;
    spi_block_addr = 32'h0010_0001;
    spi_r_block = 1'b1;
    spi_w_block = 1'b1;
    spi_data_in = 8'hEE;
    repeat (3) begin
      tick();
      if (spi_busy !== 1'b0) busy_seen++;
    end
    tests_run++;
    if (busy_seen != 0 || spi_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL both_high: got busy_cycles=%0d err=%b expected 0 and 1", busy_seen, spi_err);
    end
    close_block();
    do_init(fb, len);
    open_block(1'b1, 32'h0010_0001, len);
    tests_run++;
    if (spi_data_out !== 8'h00 || spi_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL both_high_ram: got data=%h err=%b expected 00 and 0", spi_data_out, spi_err);
    end
    close_block();
    tests_run++;
    if (spi_crc_err !== 1'b0) begin
      tests_failed++; $display("FAIL crc_err_final: got %b expected 0", spi_crc_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    spi_rst = 1'b0;
    spi_block_addr = 32'd0;
    spi_r_block = 1'b0;
    spi_r_byte = 1'b0;
    spi_r_multi_block = 1'b0;
    spi_w_block = 1'b0;
    spi_w_byte = 1'b0;
    spi_data_in = 8'h00;
    test_reset();
    test_uninit();
    test_init();
    test_write_read();
    test_out_of_range();
    test_hold_high();
    test_rst_mid_read();
    test_both_high();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
